// File: rtl/ddr2buffer_pkg.sv
// Shared FSM encoding and derived widths for the DDR-to-buffer-pool write controller.
package ddr2buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned X_MAC_DEF    = 4;
  localparam int unsigned X_MESH_DEF   = 16;
  localparam int unsigned ADDR_LEN_DEF = 9;
  localparam int unsigned DATA_LEN_DEF = 32;

  localparam int unsigned BUFFER_NUM = X_MAC_DEF * X_MESH_DEF;
  localparam int unsigned DATAWIDTH  = BUFFER_NUM * DATA_LEN_DEF;
  localparam int unsigned ADDRWIDTH  = BUFFER_NUM * ADDR_LEN_DEF;

endpackage

// File: rtl/ddr2buffer_ctrl.sv
// Streams DDR beats into the BufferPool write port, one mesh column (X_MAC buffers) per beat,
// walking mesh columns first and address rows second.
module ddr2buffer_ctrl
  import ddr2buffer_pkg::*;
#(
  parameter int unsigned X_MAC    = X_MAC_DEF,
  parameter int unsigned X_MESH   = X_MESH_DEF,
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_LEN-1:0]                  base_addr,
  input  logic [ADDR_LEN:0]                    num_rows,
  input  logic [X_MAC*DATA_LEN-1:0]            ddr_data,
  input  logic                                 ddr_valid,
  output logic                                 ddr_ready,
  output logic [X_MAC*X_MESH*DATA_LEN-1:0]     dina,
  output logic [X_MAC*X_MESH*ADDR_LEN-1:0]     addra,
  output logic [X_MAC*X_MESH-1:0]              wea,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned BufNum = X_MAC * X_MESH;
  localparam int unsigned MeshW  = (X_MESH > 1) ? $clog2(X_MESH) : 1;
  localparam int unsigned RowW   = ADDR_LEN + 1;

  state_e                       state_q, state_d;
  logic [MeshW-1:0]             mesh_q, mesh_d;
  logic [RowW-1:0]              row_q, row_d;
  logic [RowW-1:0]              rows_q, rows_d;
  logic [ADDR_LEN-1:0]          base_q, base_d;
  logic [BufNum*DATA_LEN-1:0]   dina_q, dina_d;
  logic [BufNum*ADDR_LEN-1:0]   addra_q, addra_d;
  logic [BufNum-1:0]            wea_q, wea_d;

  logic accept;
  logic last_beat;

  assign accept    = (state_q == StRun) && ddr_valid;
  assign last_beat = (mesh_q == MeshW'(X_MESH - 1)) && (row_q == rows_q - RowW'(1));

  always_comb begin
    state_d = state_q;
    mesh_d  = mesh_q;
    row_d   = row_q;
    rows_d  = rows_q;
    base_d  = base_q;
    dina_d  = dina_q;
    addra_d = addra_q;
    wea_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_addr;
          rows_d  = num_rows;
          mesh_d  = '0;
          row_d   = '0;
          state_d = (num_rows == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          // Data and address go to every buffer; only the enabled column actually writes.
          for (int b = 0; b < int'(BufNum); b++) begin
            dina_d[b*DATA_LEN +: DATA_LEN]  = ddr_data[(b % X_MAC)*DATA_LEN +: DATA_LEN];
            addra_d[b*ADDR_LEN +: ADDR_LEN] = base_q + row_q[ADDR_LEN-1:0];
          end
          wea_d[mesh_q*X_MAC +: X_MAC] = '1;
          if (mesh_q == MeshW'(X_MESH - 1)) begin
            mesh_d = '0;
            row_d  = row_q + RowW'(1);
          end else begin
            mesh_d = mesh_q + MeshW'(1);
          end
          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mesh_q  <= '0;
      row_q   <= '0;
      rows_q  <= '0;
      base_q  <= '0;
      dina_q  <= '0;
      addra_q <= '0;
      wea_q   <= '0;
    end else begin
      state_q <= state_d;
      mesh_q  <= mesh_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      base_q  <= base_d;
      dina_q  <= dina_d;
      addra_q <= addra_d;
      wea_q   <= wea_d;
    end
  end

  assign ddr_ready = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign dina      = dina_q;
  assign addra     = addra_q;
  assign wea       = wea_q;

endmodule

// File: doc/ddr2buffer_ctrl.md
DDR2BUFFER_CTRL -- requirements
Module: ddr2buffer_ctrl

Interface
REQ-001 Parameter X_MAC, default 4: buffers per mesh column, and words per DDR beat.
REQ-002 Parameter X_MESH, default 16: mesh columns.
REQ-003 Parameter ADDR_LEN, default 9: buffer address width (512 words).
REQ-004 Parameter DATA_LEN, default 32: word width; BUFFER_NUM = X_MAC*X_MESH.
REQ-005 Port clk, input, 1: single clock, all logic on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: command strobe, sampled only in IDLE.
REQ-008 Port base_addr, input, ADDR_LEN: first buffer address of the transfer.
REQ-009 Port num_rows, input, ADDR_LEN+1: address rows to fill, 0..512.
REQ-010 Port ddr_data, input, X_MAC*DATA_LEN: beat payload; word j is at bits [j*DATA_LEN +: DATA_LEN].
REQ-011 Port ddr_valid, input, 1, and port ddr_ready, output, 1: beat handshake; a beat transfers when both are high.
REQ-012 Port dina, output, BUFFER_NUM*DATA_LEN: buffer b = j+i*X_MAC at bits [b*DATA_LEN +: DATA_LEN].
REQ-013 Port addra, output, BUFFER_NUM*ADDR_LEN: buffer b at bits [b*ADDR_LEN +: ADDR_LEN].
REQ-014 Port wea, output, BUFFER_NUM: write enable bit b for buffer b.
REQ-015 Port busy, output, 1, and port done, output, 1: busy is high in RUN; done is a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start with num_rows!=0.
- IDLE->DONE on start with num_rows==0.
- RUN->DONE on acceptance of the final beat.
- DONE->IDLE unconditionally after one cycle.
REQ-017 The block SHALL latch base_addr and num_rows on start in IDLE, and SHALL ignore start in RUN and DONE.
REQ-018 ddr_ready SHALL equal (state==RUN) combinationally, with no dependence on ddr_valid.
REQ-019 The transfer SHALL consume exactly num_rows*X_MESH beats, in mesh-major order: mesh index i counts 0..X_MESH-1, then row r increments.
REQ-020 An accepted beat for (i, r) SHALL produce one registered write on the following cycle.
- wea bits i*X_MAC .. i*X_MAC+X_MAC-1 are 1; all other wea bits are 0.
- Those buffers get dina word j = ddr_data word j.
- Those buffers get addra = (base_addr + r) mod 2^ADDR_LEN, so addresses wrap from 511 to 0.
REQ-021 In any cycle following a non-accepted cycle, all wea bits SHALL be 0; dina and addra are don't-care while wea=0.
REQ-022 ddr_valid stalls SHALL insert write-free cycles, and SHALL NOT skip or repeat any (i, r) position.
REQ-023 done SHALL be high exactly one cycle, while in DONE, which coincides with the final write's wea pulse; for a num_rows==0 start, done SHALL be high one cycle after start with no writes.
REQ-024 busy SHALL be high exactly while the state is RUN.
REQ-025 The block SHALL sustain a throughput of one beat per cycle.

Reset
REQ-026 rst SHALL force the following on the next edge, including mid-transfer:
- state IDLE;
- wea all 0;
- busy=0, done=0, ddr_ready=0;
- counters 0;
- dina and addra 0.
REQ-027 A transfer aborted by reset SHALL NOT resume, and SHALL produce no further writes.

Structure
REQ-028 Package ddr2buffer_pkg SHALL hold the FSM state encoding and the derived widths BUFFER_NUM, DATAWIDTH and ADDRWIDTH.
REQ-029 The block SHALL be a single module with no sub-modules; its outputs SHALL connect directly to the BufferPool write port (dina, addra, wea), with clk shared.

Verification
REQ-030 Basic fill:
- Stimulus: base_addr=3, num_rows=2, ddr_valid always 1, beat k data words = 16k+j.
- Response: 32 beats; beat 5 (i=5, r=0) writes buffers 20..23 at address 3 with 80..83.
- Response: beat 21 (i=5, r=1) writes buffers 20..23 at address 4 with 336..339.
- Response: done pulses on the cycle of the 32nd write.
REQ-031 Wrap:
- Stimulus: base_addr=511, num_rows=2.
- Response: row 0 is written at address 511 and row 1 at address 0.
REQ-032 Stall:
- Stimulus: ddr_valid toggling 1,0,1,0.
- Response: wea pulses every other cycle; the written sequence matches REQ-030; ddr_ready stays 1 throughout RUN.
REQ-033 Zero length:
- Stimulus: num_rows=0.
- Response: done one cycle after start; wea never asserted; ddr_ready stays 0.
REQ-034 Reset mid-transfer:
- Stimulus: rst asserted after beat 10.
- Response: the next cycle has wea=0 and busy=0; a new start then begins at i=0, r=0.
REQ-035 Start while busy:
- Stimulus: start pulsed in RUN with different base_addr and num_rows.
- Response: ignored; the original transfer completes unchanged.
